// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared widths, index constants and types for the write-back register file.
package msrv32_pkg;
    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;
    localparam int REG_DEPTH = 2 ** REG_AW;
    typedef logic [XLEN-1:0]      data_t;
    typedef logic [REG_AW-1:0]    reg_idx_t;
    typedef logic [REG_DEPTH-1:0] busy_vec_t;
    localparam reg_idx_t REG_X0 = '0;
endpackage

// File: rtl/msrv32_scoreboard_unit.sv
// msrv32_scoreboard_unit: busy bits for in-flight destinations and source hazard detection.
import msrv32_pkg::*;

module msrv32_scoreboard_unit (
    input  logic      clk,
    input  logic      i_rst_n,
    input  logic      i_issue_valid,
    input  reg_idx_t  i_issue_rd,
    input  logic      i_wb_valid,
    input  reg_idx_t  i_wb_rd,
    input  logic      i_flush,
    input  reg_idx_t  i_rs_1_addr,
    input  reg_idx_t  i_rs_2_addr,
    output logic      o_hazard,
    output busy_vec_t o_busy_vec
);
    localparam busy_vec_t ONE = busy_vec_t'(1);
    busy_vec_t r_busy;
    busy_vec_t w_set;
    busy_vec_t w_clr;
    busy_vec_t w_busy_m;
    always_comb begin
        w_set    = (i_issue_valid ? (ONE << i_issue_rd) : '0) & ~ONE;
        w_clr    = i_wb_valid ? (ONE << i_wb_rd) : '0;
        // a source retiring this cycle is served by the bypass, so it is not a hazard
        w_busy_m = r_busy & ~w_clr;
        o_hazard = i_rst_n & ((w_busy_m[i_rs_1_addr] & (i_rs_1_addr != REG_X0)) |
                              (w_busy_m[i_rs_2_addr] & (i_rs_2_addr != REG_X0)));
        o_busy_vec = i_rst_n ? r_busy : '0;
    end
    always_ff @(posedge clk) begin
        if (!i_rst_n)
            r_busy <= '0;
        else if (i_flush)
            r_busy <= '0;
        else
            r_busy <= (r_busy & ~w_clr) | w_set;
    end
endmodule

// File: rtl/msrv32_wb_reg_file_unit.sv
// msrv32_wb_reg_file_unit: RV32I register file with write-back commit, bypassed reads and scoreboard.
import msrv32_pkg::*;

module msrv32_wb_reg_file_unit (
    input  logic      ms_riscv32_mp_clk_in,
    input  logic      ms_riscv32_mp_rst_in,
    input  logic      wb_valid_in,
    input  reg_idx_t  wb_rd_in,
    input  data_t     wb_data_in,
    input  logic      issue_valid_in,
    input  reg_idx_t  issue_rd_in,
    input  logic      flush_in,
    input  reg_idx_t  rs_1_addr_in,
    input  reg_idx_t  rs_2_addr_in,
    output data_t     rs_1_out,
    output data_t     rs_2_out,
    output logic      hazard_out,
    output busy_vec_t busy_vec_out
);
    data_t r_regs [REG_DEPTH];
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in)
            for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
        else if (wb_valid_in && wb_rd_in != REG_X0)
            r_regs[wb_rd_in] <= wb_data_in;
    end
    always_comb begin
        rs_1_out = (!ms_riscv32_mp_rst_in || rs_1_addr_in == REG_X0) ? '0 :
                   (wb_valid_in && wb_rd_in == rs_1_addr_in) ? wb_data_in : r_regs[rs_1_addr_in];
        rs_2_out = (!ms_riscv32_mp_rst_in || rs_2_addr_in == REG_X0) ? '0 :
                   (wb_valid_in && wb_rd_in == rs_2_addr_in) ? wb_data_in : r_regs[rs_2_addr_in];
    end
    msrv32_scoreboard_unit u_scoreboard (
        .clk           (ms_riscv32_mp_clk_in),
        .i_rst_n       (ms_riscv32_mp_rst_in),
        .i_issue_valid (issue_valid_in),
        .i_issue_rd    (issue_rd_in),
        .i_wb_valid    (wb_valid_in),
        .i_wb_rd       (wb_rd_in),
        .i_flush       (flush_in),
        .i_rs_1_addr   (rs_1_addr_in),
        .i_rs_2_addr   (rs_2_addr_in),
        .o_hazard      (hazard_out),
        .o_busy_vec    (busy_vec_out)
    );
endmodule

// File: tb/tb_msrv32_wb_reg_file_unit.sv
// tb_msrv32_wb_reg_file_unit: directed checks of write, bypass, x0, scoreboard and reset behaviour.
module tb_msrv32_wb_reg_file_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_out, rs2_out;
    logic        hazard;
    logic [31:0] busy_vec;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_wb_reg_file_unit dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .wb_valid_in          (wb_valid),
        .wb_rd_in             (wb_rd),
        .wb_data_in           (wb_data),
        .issue_valid_in       (issue_valid),
        .issue_rd_in          (issue_rd),
        .flush_in             (flush),
        .rs_1_addr_in         (rs1),
        .rs_2_addr_in         (rs2),
        .rs_1_out             (rs1_out),
        .rs_2_out             (rs2_out),
        .hazard_out           (hazard),
        .busy_vec_out         (busy_vec)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; issue_valid = 0; flush = 0;
        wb_rd = 0; wb_data = 0; issue_rd = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; rs1 = 5; rs2 = 5;
        wb_valid = 1; wb_rd = 5; wb_data = 32'hCAFE_F00D;
        #1;
        checks++;
        if (rs1_out !== 32'h0) begin errors++; $display("FAIL reset_rs1_gated got=%h exp=%h", rs1_out, 32'h0); end
        step();
        step();
        idle();
        rst_n = 1;
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(i);
            #1;
            checks++;
            if (rs1_out !== 32'h0 || rs2_out !== 32'h0) begin
                errors++; $display("FAIL reset_read x%0d got=%h/%h exp=0", i, rs1_out, rs2_out);
            end
        end
        checks++;
        if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
    endtask

    task automatic test_bypass();
        idle();
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF; rs1 = 5; rs2 = 6;
        #1;
        checks++;
        if (rs1_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", rs1_out, 32'hDEAD_BEEF); end
        checks++;
        if (rs2_out !== 32'h0) begin errors++; $display("FAIL bypass_other_reg got=%h exp=0", rs2_out); end
        step();
        idle();
        #1;
        checks++;
        if (rs1_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_stored got=%h exp=%h", rs1_out, 32'hDEAD_BEEF); end
    endtask

    task automatic test_x0();
        idle();
        wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
        issue_valid = 1; issue_rd = 0; rs2 = 0; rs1 = 0;
        #1;
        checks++;
        if (rs2_out !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rs2_out); end
        step();
        idle();
        #1;
        checks++;
        if (rs2_out !== 32'h0) begin errors++; $display("FAIL x0_read got=%h exp=0", rs2_out); end
        checks++;
        if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy got=%h exp=0", busy_vec); end
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard got=%b exp=0", hazard); end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1; issue_rd = 7; rs1 = 0; rs2 = 0;
        step();
        idle();
        rs2 = 7;
        #1;
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_set got=%b exp=1", hazard); end
        checks++;
        if (busy_vec !== 32'h0000_0080) begin errors++; $display("FAIL sb_busy_set got=%h exp=%h", busy_vec, 32'h80); end
        wb_valid = 1; wb_rd = 7; wb_data = 32'h12;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL sb_hazard_masked got=%b exp=0", hazard); end
        checks++;
        if (rs2_out !== 32'h12) begin errors++; $display("FAIL sb_bypass got=%h exp=%h", rs2_out, 32'h12); end
        step();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_busy_clear got=%h exp=0", busy_vec); end
        checks++;
        if (rs2_out !== 32'h12 || hazard !== 1'b0) begin errors++; $display("FAIL sb_after got=%h/%b exp=%h/0", rs2_out, hazard, 32'h12); end
    endtask

    task automatic test_set_clear_flush();
        idle();
        issue_valid = 1; issue_rd = 9; wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
        step();
        idle();
        rs1 = 9; rs2 = 0;
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL set_over_clear got=%h exp=%h", busy_vec, 32'h200); end
        checks++;
        if (hazard !== 1'b1 || rs1_out !== 32'h99) begin errors++; $display("FAIL set_clear_rs1 got=%b/%h exp=1/%h", hazard, rs1_out, 32'h99); end
        flush = 1; issue_valid = 1; issue_rd = 3;
        step();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin errors++; $display("FAIL flush got=%h exp=0", busy_vec); end
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL flush_hazard got=%b exp=0", hazard); end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 1; i <= 3; i++) begin
            wb_valid = 1; wb_rd = 5'(10 + i); wb_data = 32'h1000 * i + 32'(i);
            step();
        end
        idle();
        rs1 = 11; rs2 = 13;
        #1;
        checks++;
        if (rs1_out !== 32'h0000_1001 || rs2_out !== 32'h0000_3003) begin
            errors++; $display("FAIL b2b_read got=%h/%h exp=%h/%h", rs1_out, rs2_out, 32'h1001, 32'h3003);
        end
        rs1 = 12;
        #1;
        checks++;
        if (rs1_out !== 32'h0000_2002) begin errors++; $display("FAIL b2b_mid got=%h exp=%h", rs1_out, 32'h2002); end
    endtask

    task automatic test_reset_mid();
        idle();
        issue_valid = 1; issue_rd = 4; wb_valid = 1; wb_rd = 4; wb_data = 32'h55;
        step();
        idle();
        rs1 = 4; rs2 = 0;
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0010 || rs1_out !== 32'h55) begin
            errors++; $display("FAIL mid_setup got=%h/%h exp=%h/%h", busy_vec, rs1_out, 32'h10, 32'h55);
        end
        rst_n = 0; wb_valid = 1; wb_rd = 4; wb_data = 32'hAA; issue_valid = 1; issue_rd = 6;
        step();
        rst_n = 1;
        idle();
        #1;
        checks++;
        if (rs1_out !== 32'h0) begin errors++; $display("FAIL mid_reset_reg got=%h exp=0", rs1_out); end
        checks++;
        if (busy_vec !== 32'h0 || hazard !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%h/%b exp=0/0", busy_vec, hazard); end
    endtask

    initial begin
        rst_n = 0; rs1 = 0; rs2 = 0;
        idle();
        #2;
        test_reset();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_set_clear_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/msrv32_wb_reg_file_unit.md
Name: msrv32_wb_reg_file_unit

Overview:
- Receiving end of the write-back path: takes the selected 32-bit write-back value and destination index, and commits it to the 32 x 32 RV32I integer register file.
- Provides two combinational read ports (rs1/rs2) with write-through bypass.
- Holds a busy-bit scoreboard for in-flight destinations and raises a hazard to the pipeline control when a source is not yet written back.
- Sits between the write-back mux stage and the decode/operand-fetch stage.

Parameters:
- XLEN, 32, data width of each register.
- REG_AW, 5, register index width; depth is 2**REG_AW.

Ports:
- ms_riscv32_mp_clk_in  input  1  sole clock; all state updates on its rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-low reset.
- wb_valid_in  input  1  write-back commit strobe.
- wb_rd_in  input  REG_AW  destination register index.
- wb_data_in  input  XLEN  write-back data from the mux stage.
- issue_valid_in  input  1  an instruction writing rd is issued this cycle.
- issue_rd_in  input  REG_AW  destination of the issued instruction.
- flush_in  input  1  pipeline flush; discards all pending destinations.
- rs_1_addr_in  input  REG_AW  read port 1 index.
- rs_2_addr_in  input  REG_AW  read port 2 index.
- rs_1_out  output  XLEN  read port 1 data.
- rs_2_out  output  XLEN  read port 2 data.
- hazard_out  output  1  a source register is pending write-back.
- busy_vec_out  output  2**REG_AW  scoreboard state, for debug and verification.

Behaviour:
- Reset: sampled only on a rising clock edge while ms_riscv32_mp_rst_in = 0.
  - Clears all registers x1..x31 to 0 and all busy bits to 0.
  - Reset has priority over wb_valid_in, issue_valid_in and flush_in in the same cycle.
  - While in reset and in the cycle after: rs_1_out = rs_2_out = 0, hazard_out = 0, busy_vec_out = 0.
- x0:
  - Writes with wb_rd_in = 0 are discarded.
  - Reads of index 0 always return 0.
  - busy[0] is never set; issue_rd_in = 0 is ignored.
- Write: when wb_valid_in = 1 and wb_rd_in != 0, reg[wb_rd_in] <= wb_data_in at the clock edge. Write latency is 1 cycle.
- Read: combinational.
  - rs_N_out = 0 if rs_N_addr = 0.
  - Otherwise rs_N_out = wb_data_in if wb_valid_in = 1 and wb_rd_in = rs_N_addr (same-cycle bypass).
  - Otherwise rs_N_out = reg[rs_N_addr].
- Scoreboard, per register i != 0, evaluated at the clock edge:
  - Flush: if flush_in = 1, busy[i] <= 0 for all i. This overrides set and clear; the write itself still commits.
  - Set: if issue_valid_in = 1 and issue_rd_in = i, busy[i] <= 1. Set has priority over a simultaneous clear of the same index, because the new producer supersedes the retiring one.
  - Clear: if wb_valid_in = 1 and wb_rd_in = i, busy[i] <= 0.
  - A write-back to a non-busy register is legal; it writes and busy stays 0.
- Hazard: combinational. hazard_out = (busy[rs_1_addr] and rs_1_addr != 0) or (busy[rs_2_addr] and rs_2_addr != 0).
  - A source whose write-back is happening this cycle does not raise a hazard, since the bypass supplies the data. This is implemented as busy masked by (wb_valid_in and wb_rd_in matches).
- No arithmetic; data passes unmodified at XLEN width.
- Out-of-range indices cannot occur because the depth is exactly 2**REG_AW.

Decomposition:
- Shared package msrv32_pkg:
  - XLEN and REG_AW.
  - Register-index constant REG_X0 = 0.
  - Width typedefs for data and register index.
- One natural sub-module: msrv32_scoreboard_unit.
  - Owns the busy vector, set/clear/flush priority and the hazard masking.
  - The top level holds the storage array and the bypass read muxes.

Test Plan:
- Reset then read: assert reset for 2 cycles, read x1..x31 -> all 0, busy_vec_out = 0, hazard_out = 0.
- Write/read with bypass: wb_valid=1, rd=5, data=0xDEADBEEF with rs_1_addr=5 in the same cycle -> rs_1_out = 0xDEADBEEF combinationally; next cycle with wb_valid=0 -> rs_1_out still 0xDEADBEEF.
- x0 protection: wb_valid=1, rd=0, data=0xFFFFFFFF; issue rd=0 -> rs_2_addr=0 reads 0, busy[0]=0, hazard_out=0.
- Scoreboard lifecycle: issue rd=7; next cycle rs_2_addr=7 -> hazard_out=1; write back rd=7 data=0x12 -> hazard_out=0 in that cycle, rs_2_out=0x12; busy[7]=0 afterwards.
- Simultaneous set/clear and flush:
  - Same cycle issue rd=9 and write back rd=9 -> busy[9]=1.
  - Then flush_in=1 together with issue rd=3 -> busy_vec_out=0.
- Reset mid-operation: busy[4]=1 and reg x4=0x55, then reset asserted together with wb_valid rd=4 data=0xAA -> x4=0, busy[4]=0.
